// File: rtl/emu_ram_scan_ctrl_if.sv
// rtl/emu_ram_scan_ctrl_if.sv - handshake and scan-chain bundle for emu_ram_scan_ctrl
// Signals:
//   cmd_valid/cmd_dir/cmd_ready   start request, 0=dump 1=restore
//   busy/done/pause               sequence status, one-cycle done, DUT clock-gate hold
//   ram_se/ram_sd/ram_sdi/ram_sdo RAM scan chain enable, direction, data in, data out
//   out_valid/out_ready/out_data  dump stream
//   in_valid/in_ready/in_data     restore stream
// Modports: slave = controller side, master = host/chain side.
interface emu_ram_scan_ctrl_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  cmd_valid;
   logic                  cmd_dir;
   logic                  cmd_ready;
   logic                  busy;
   logic                  done;
   logic                  pause;
   logic                  ram_se;
   logic                  ram_sd;
   logic [DATA_WIDTH-1:0] ram_sdi;
   logic [DATA_WIDTH-1:0] ram_sdo;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;

   modport slave (
      input  cmd_valid, cmd_dir, ram_sdo, out_ready, in_valid, in_data,
      output cmd_ready, busy, done, pause, ram_se, ram_sd, ram_sdi,
             out_valid, out_data, in_ready
   );

   modport master (
      output cmd_valid, cmd_dir, ram_sdo, out_ready, in_valid, in_data,
      input  cmd_ready, busy, done, pause, ram_se, ram_sd, ram_sdi,
             out_valid, out_data, in_ready
   );
endinterface

// File: rtl/emu_ram_scan_ctrl.sv
// rtl/emu_ram_scan_ctrl.sv - RAM scan chain dump/restore sequencer
// Ports:
//   clk    free-running emulator clock, also advances the scan chain
//   rst_n  asynchronous active-low reset
//   bus    slave modport: command handshake, clock-gate pause, scan chain,
//          dump stream (through a skid FIFO) and restore stream
module emu_ram_scan_ctrl #(
   parameter int DATA_WIDTH  = 64,
   parameter int CHAIN_WORDS = 4,
   parameter int READ_LAT    = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   emu_ram_scan_ctrl_if.slave bus
);
   localparam int CW_W = $clog2(CHAIN_WORDS + 1);
   localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FC_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PAUSE, S_DUMP, S_DRAIN, S_RESTORE, S_TAIL, S_RELEASE
   } state_e;

   state_e                state_q, state_d;
   logic                  dir_q, dir_d;
   logic [CW_W-1:0]       cnt_q, cnt_d;
   logic                  done_q;
   logic [READ_LAT-1:0]   rd_pipe_q;
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [FC_W-1:0]       fcnt_q;

   logic                  se, pause, in_rdy, dump_se;
   logic [DATA_WIDTH-1:0] sdi;
   logic                  push, pop, out_vld;
   logic                  credit_ok, words_left;
   int                    inflight;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign inflight   = $countones(rd_pipe_q);
   // Reads in flight reserve FIFO space so a stalled stream can never overflow it.
   assign credit_ok  = (int'(fcnt_q) + inflight) < FIFO_DEPTH;
   assign words_left = cnt_q < CW_W'(CHAIN_WORDS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         done_q  <= (state_q == S_RELEASE);
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               dir_d   = bus.cmd_dir;
               cnt_d   = '0;
               state_d = S_PAUSE;
            end
         end
         S_PAUSE:   state_d = dir_q ? S_RESTORE : S_DUMP;
         S_DUMP: begin
            if (se) begin
               cnt_d = cnt_q + CW_W'(1);
               if (cnt_q == CW_W'(CHAIN_WORDS - 1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (inflight == 0 && fcnt_q == '0) state_d = S_RELEASE;
         end
         S_RESTORE: begin
            if (se) begin
               cnt_d = cnt_q + CW_W'(1);
               if (cnt_q == CW_W'(CHAIN_WORDS - 1)) state_d = S_TAIL;
            end
         end
         S_TAIL:    state_d = S_RELEASE;
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pause  = 1'b0;
      se     = 1'b0;
      sdi    = '0;
      in_rdy = 1'b0;
      unique case (state_q)
         S_IDLE: ;
         S_DUMP: begin
            pause = 1'b1;
            se    = words_left && credit_ok;
         end
         S_RESTORE: begin
            pause  = 1'b1;
            in_rdy = words_left;
            se     = bus.in_valid && words_left;
            sdi    = se ? bus.in_data : '0;
         end
         // Commit cycle: the chain needs one extra shift with zero data to land the last word.
         S_TAIL: begin
            pause = 1'b1;
            se    = 1'b1;
         end
         default: pause = 1'b1;
      endcase
   end

   assign dump_se       = se && (state_q == S_DUMP);
   assign push          = rd_pipe_q[READ_LAT-1];
   assign out_vld       = (fcnt_q != '0);
   assign pop           = out_vld && bus.out_ready;

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;
   assign bus.pause     = pause;
   assign bus.ram_se    = se;
   assign bus.ram_sd    = (state_q != S_IDLE) && dir_q;
   assign bus.ram_sdi   = sdi;
   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.out_data  = fifo_mem[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pipe_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fcnt_q    <= '0;
      end else begin
         // Valid shift pipe: bit READ_LAT-1 marks the cycle ram_sdo carries an issued word.
         rd_pipe_q <= READ_LAT'({rd_pipe_q, dump_se});
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         fcnt_q <= fcnt_q + FC_W'(push) - FC_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= bus.ram_sdo;
   end
endmodule
